// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline stage register with valid/ready, skid entry, flush and stall counter
module pipe_stage_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGISTER_WIDTH = 5,
  parameter int NUM_DATA       = 4,
  parameter int SKID_EN        = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] data_i,
  input  logic [REGISTER_WIDTH-1:0]      rd_i,
  input  logic [1:0]                     result_src_i,
  input  logic                           reg_write_i,
  input  logic                           flush_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [NUM_DATA*DATA_WIDTH-1:0] data_o,
  output logic [REGISTER_WIDTH-1:0]      rd_o,
  output logic [1:0]                     result_src_o,
  output logic                           reg_write_o,
  output logic [CNT_WIDTH-1:0]           stall_cnt_o
);

  localparam int PW = NUM_DATA*DATA_WIDTH + REGISTER_WIDTH + 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [PW-1:0]        main_q;
  logic [PW-1:0]        skid_q;
  logic [PW-1:0]        in_bus;
  logic                 load_main_in;
  logic                 load_main_skid;
  logic                 load_skid;
  logic                 reg_write_main;
  logic [CNT_WIDTH-1:0] stall_cnt;

  assign in_bus = {data_i, rd_i, result_src_i, reg_write_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = EMPTY;
    end else if (SKID_EN != 0) begin
      case (state)
        EMPTY: if (valid_i) state_next = FULL;
        FULL: begin
          if (ready_i && !valid_i) begin
            state_next = EMPTY;
          end else if (valid_i && !ready_i) begin
            state_next = SKID;
          end
        end
        SKID: if (ready_i) state_next = FULL;
        default: state_next = EMPTY;
      endcase
    end else begin
      // Without a skid entry the stage only ever holds one beat.
      if (valid_i && (ready_i || state == EMPTY)) begin
        state_next = FULL;
      end else if (state != EMPTY && ready_i) begin
        state_next = EMPTY;
      end
    end
  end

  always_comb begin
    valid_o        = (state != EMPTY);
    ready_o        = (SKID_EN != 0) ? (state != SKID) : (ready_i || state == EMPTY);
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush_i) begin
      if (SKID_EN != 0) begin
        case (state)
          EMPTY: load_main_in = valid_i;
          FULL: begin
            load_main_in = valid_i && ready_i;
            load_skid    = valid_i && !ready_i;
          end
          SKID: load_main_skid = ready_i;
          default: load_main_in = 1'b0;
        endcase
      end else begin
        load_main_in = valid_i && (ready_i || state == EMPTY);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (load_main_in) begin
      main_q <= in_bus;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_bus;
    end
  end

  // Counts every held cycle, flushed or not; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (valid_o && !ready_i && stall_cnt != {CNT_WIDTH{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign {data_o, rd_o, result_src_o, reg_write_main} = main_q;
  assign reg_write_o = reg_write_main && valid_o;
  assign stall_cnt_o = stall_cnt;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; the successor to the fixed MEM/WB register.
- Carries NUM_DATA data words, a destination register index and writeback control between any two pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (selectable by mode), synchronous flush, asynchronous active-low reset and a saturating stall counter.
- Instantiated between MEM and WB first; EX/MEM to follow.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- REGISTER_WIDTH, 5, width of the destination register index.
- NUM_DATA, 4, number of data words (alu_result, pc_plus4, read_data, imm_ext at MEM/WB).
- SKID_EN, 1, 1 = registered ready_o with skid entry; 0 = plain enable register with combinational ready_o.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream payload valid.
- ready_o  out  1  stage can accept the payload this cycle.
- data_i  in  NUM_DATA*DATA_WIDTH  packed data words; word k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- rd_i  in  REGISTER_WIDTH  destination register index.
- result_src_i  in  2  writeback mux select.
- reg_write_i  in  1  register-file write enable.
- flush_i  in  1  synchronous kill of all held payload.
- valid_o  out  1  output payload valid.
- ready_i  in  1  downstream accepts the payload.
- data_o  out  NUM_DATA*DATA_WIDTH  registered data words.
- rd_o  out  REGISTER_WIDTH  registered destination index.
- result_src_o  out  2  registered writeback select.
- reg_write_o  out  1  registered write enable, qualified as reg_write_main AND valid_o.
- stall_cnt_o  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; valid_o=0; data_o, rd_o, result_src_o, reg_write_o = 0; skid entry cleared; stall_cnt_o=0.
- Reset asserted mid-transfer discards all held payload with no partial update.
- Handshakes:
  - Upstream transfer when valid_i && ready_o.
  - Downstream transfer when valid_o && ready_i.
  - Latency input to output is 1 cycle.
- Payload outputs always come from the main entry. valid_o = (state != EMPTY).
- State machine, SKID_EN=1; ready_o = (state != SKID), registered:
  - EMPTY: valid_i -> load main, go to FULL; otherwise stay.
  - FULL, valid_i && ready_i: main <= input, stay FULL.
  - FULL, !valid_i && ready_i: go to EMPTY.
  - FULL, valid_i && !ready_i: skid <= input, go to SKID.
  - FULL, !valid_i && !ready_i: hold.
  - SKID: ready_i -> main <= skid, go to FULL; otherwise hold. valid_i is ignored because ready_o=0.
- SKID_EN=0:
  - ready_o = ready_i || !valid_o, combinational.
  - State is only EMPTY or FULL. Main loads on any upstream transfer.
  - Main holds when valid_o && !ready_i. Goes EMPTY when it drains with no new input.
- flush_i has highest priority after reset:
  - Next state EMPTY; valid_o=0 next cycle.
  - Input payload of the same cycle is dropped even if valid_i && ready_o.
  - Payload registers may retain stale values, but reg_write_o must read 0.
- Gating: reg_write_o is never 1 while valid_o=0, including after flush.
- Stall counter:
  - Increments by 1 on each cycle with valid_o && !ready_i.
  - Saturates at 2^CNT_WIDTH-1 with no wrap.
  - Cleared only by reset; flush does not clear it.
- No payload loss: every accepted input appears exactly once on the output in order, unless flushed.
- No payload duplication: the same beat is never presented twice.

Test Plan:
- Streaming: SKID_EN=1, ready_i=1, 8 back-to-back beats with rd_i=1..8 -> rd_o=1..8 one cycle later, valid_o continuous, stall_cnt_o=0.
- Backpressure into skid: beats A (rd=3) and B (rd=4) on consecutive cycles, ready_i dropped when A is on the output -> state SKID, ready_o=0 next cycle, A held. On ready_i=1: A transfers, then B, with no loss and stall_cnt_o=1 per held cycle.
- Flush while in SKID with valid_i=1 (rd=9) -> next cycle valid_o=0, reg_write_o=0. rd=9 never appears; subsequent beat rd=10 passes normally.
- Asynchronous reset: assert rst_n=0 between clock edges while FULL with reg_write=1 and data word 0 = 0xDEADBEEF -> outputs zero immediately, before the next edge. After release, first beat passes with 1-cycle latency.
- SKID_EN=0, ready_i=0 with valid_o=1 -> ready_o=0 in the same cycle and data held. ready_i=1 with valid_i=1 -> ready_o=1 and the new beat loads on that edge.
- Saturation: CNT_WIDTH=4, hold valid_o=1 with ready_i=0 for 20 cycles -> stall_cnt_o=15, no wrap.
